// File: rtl/sram_host_pkg.sv
// Shared types and constants for the sram host-side controller.
package sram_host_pkg;

  // Width of the saturating error-response counter.
  localparam int ERR_CNT_W = 8;

  // Upper bounds for the request latch fields. Instances use the low bits only.
  localparam int MAX_AW = 16;
  localparam int MAX_DW = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } sram_host_state_e;

  typedef struct packed {
    logic              write;
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] wdata;
  } sram_req_t;

  // True when a word address falls inside the implemented depth.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/sram_host_ctrl.sv
// Host-side controller for the single-port sram: one request at a time,
// one-cycle memory strobe, registered response with range checking.
module sram_host_ctrl
  import sram_host_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [DW-1:0]        req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic [ERR_CNT_W-1:0] err_count
);

  if (DEPTH > (32'd1 << AW)) begin : g_bad_depth
    $error("sram_host_ctrl: DEPTH exceeds 2**AW");
  end
  if ((AW > MAX_AW) || (DW > MAX_DW)) begin : g_bad_width
    $error("sram_host_ctrl: AW/DW exceed request latch width");
  end

  sram_host_state_e     state_q,     state_d;
  sram_req_t            req_q,       req_d;
  logic                 illegal_q,   illegal_d;
  logic                 mem_we_q,    mem_we_d;
  logic                 mem_re_q,    mem_re_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

  logic addr_ok;
  assign addr_ok = addr_in_range(32'(req_addr), DEPTH);

  // State and all output registers; everything clears on reset so the
  // memory interface goes quiet immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      illegal_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      illegal_q   <= illegal_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state and output decode. Strobes default low so each lasts one cycle.
  // Out-of-range requests also pass through ISSUE (without a strobe) so that
  // every non-read response appears one cycle after acceptance.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    illegal_d   = illegal_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ISSUE;
          if (addr_ok) begin
            illegal_d   = 1'b0;
            req_d.write = req_write;
            req_d.addr  = MAX_AW'(req_addr);
            req_d.wdata = MAX_DW'(req_wdata);
            mem_we_d    = req_write;
            mem_re_d    = !req_write;
          end else begin
            illegal_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (illegal_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (req_q.write) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = mem_rdata;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the low AW/DW bits of the latch drive the memory.
  logic unused_req_bits;
  assign unused_req_bits = ^req_q;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = req_q.addr[AW-1:0];
  assign mem_wdata = req_q.wdata[DW-1:0];
  assign err_count = err_cnt_q;

endmodule
